// File: rtl/act_group_encoder_pkg.sv
// Shared widths and state encoding for the activation group encoder and its dispatcher.
package act_group_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_e;

    function automatic int rep_info_w(input int group_size);
        return group_size * group_size;
    endfunction

    function automatic int zero_info_w(input int group_size);
        return group_size;
    endfunction

    function automatic int output_w(input int group_size, input int data_width);
        return group_size * data_width + rep_info_w(group_size) + zero_info_w(group_size);
    endfunction

endpackage

// File: rtl/act_group_encoder_rep.sv
// act_rep_detect: combinational repetition/zero detection over one full group.
// Repetition comparators exist only when ACT_ENC_REP_EN is defined.
module act_rep_detect
    import act_group_encoder_pkg::*;
#(
    parameter int GROUP_SIZE = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] group,
    output logic [GROUP_SIZE*GROUP_SIZE-1:0]      rep,
    output logic [GROUP_SIZE-1:0]                 zero
);

    for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_zero
        assign zero[i] = (group[i] == '0);
    end

`ifdef ACT_ENC_REP_EN
    // Only the strictly-lower triangle marks a repeat of an earlier element.
    for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_row
        for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_col
            if (j < i) begin : g_cmp
                assign rep[i*GROUP_SIZE+j] = (group[i] == group[j]);
            end else begin : g_nocmp
                assign rep[i*GROUP_SIZE+j] = 1'b0;
            end
        end
    end
`else
    assign rep = '0;
`endif

endmodule

// File: rtl/act_group_encoder.sv
// Activation group encoder: packs GROUP_SIZE activations into {zero, rep, data} words.
// Optional macro ACT_ENC_REP_EN enables the repetition matrix.
module act_group_encoder
    import act_group_encoder_pkg::*;
#(
    parameter int GROUP_SIZE             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    localparam int REP_INFO  = rep_info_w(GROUP_SIZE),
    localparam int ZERO_INFO = zero_info_w(GROUP_SIZE),
    localparam int OUTPUT    = output_w(GROUP_SIZE, DATA_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [OUTPUT-1:0]                 data_out,
    output logic                              valid_out,
    input  logic                              avail_in
);

    localparam int CNT_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

    enc_state_e state_q, state_d;

    logic [CNT_W-1:0]                      elem_cnt;
    logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] slots;
    logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] group;
    logic [LOG_MAX_READS_PER_ITER-1:0]     read_cnt, num_reads_q;
    logic [LOG_MAX_ITERS-1:0]              iter_cnt, num_iters_q;
    logic [REP_INFO-1:0]                   rep;
    logic [ZERO_INFO-1:0]                  zero;

    logic xfer_in, xfer_out, last_elem, last_read, last_group;

    assign last_elem  = (elem_cnt == CNT_W'(GROUP_SIZE - 1));
    assign last_read  = (read_cnt == num_reads_q - LOG_MAX_READS_PER_ITER'(1));
    assign last_group = last_read && (iter_cnt == num_iters_q - LOG_MAX_ITERS'(1));

    // Only the closing element has to wait for the consumer; others fill the collector.
    assign avail_out = (state_q == RUN) && !(last_elem && valid_out && !avail_in);
    assign xfer_in   = valid_in && avail_out;
    assign xfer_out  = valid_out && avail_in;

    always_comb begin
        group                 = slots;
        group[GROUP_SIZE-1]   = data_in;
    end

    act_rep_detect #(
        .GROUP_SIZE (GROUP_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rep_detect (
        .group (group),
        .rep   (rep),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (configure)
            state_d = (num_iters != '0 && num_reads_per_iter != '0) ? RUN : IDLE;
        else if (state_q == RUN && xfer_out && last_group)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem_cnt    <= '0;
            slots       <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            read_cnt    <= '0;
            iter_cnt    <= '0;
            num_reads_q <= '0;
            num_iters_q <= '0;
        end else if (configure) begin
            elem_cnt    <= '0;
            slots       <= '0;
            valid_out   <= 1'b0;
            read_cnt    <= '0;
            iter_cnt    <= '0;
            num_reads_q <= num_reads_per_iter;
            num_iters_q <= num_iters;
        end else begin
            if (xfer_out) begin
                valid_out <= 1'b0;
                if (last_group) begin
                    read_cnt <= '0;
                    iter_cnt <= '0;
                end else if (last_read) begin
                    read_cnt <= '0;
                    iter_cnt <= iter_cnt + LOG_MAX_ITERS'(1);
                end else begin
                    read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
                end
            end
            // A closing accept in the same cycle as a transfer overwrites the word and keeps valid high.
            if (xfer_in) begin
                slots[elem_cnt] <= data_in;
                if (last_elem) begin
                    elem_cnt  <= '0;
                    data_out  <= {zero, rep, group};
                    valid_out <= 1'b1;
                end else begin
                    elem_cnt <= elem_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_act_group_encoder.sv
// Directed plus randomized bench for act_group_encoder against a transaction-level group model.
module tb_act_group_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        configure;
    logic [15:0] num_iters;
    logic [15:0] num_reads_per_iter;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        avail_out;
    logic [51:0] data_out;
    logic        valid_out;
    logic        avail_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: current partial group, pending words, groups still owed in the run.
    logic [7:0]  mg [4];
    int          mcnt;
    bit          mrun;
    int          mleft;
    logic [51:0] pend [$];

`ifdef ACT_ENC_REP_EN
    localparam logic [15:0] REP_A = 16'h0100;
    localparam logic [15:0] REP_B = 16'h7310;
`else
    localparam logic [15:0] REP_A = 16'h0000;
    localparam logic [15:0] REP_B = 16'h0000;
`endif

    act_group_encoder dut (
        .clk                (clk),
        .rst                (rst),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .data_in            (data_in),
        .valid_in           (valid_in),
        .avail_out          (avail_out),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .avail_in           (avail_in)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] enc(input logic [7:0] g [4]);
        logic [31:0] d;
        logic [15:0] r;
        logic [3:0]  z;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d[i*8 +: 8] = g[i];
            z[i] = (g[i] == 8'd0);
`ifdef ACT_ENC_REP_EN
            for (int j = 0; j < i; j++)
                if (g[i] == g[j]) r[i*4+j] = 1'b1;
`endif
        end
        return {z, r, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mcnt  = 0;
        mrun  = 0;
        mleft = 0;
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic tick();
        bit eav;
        #1;
        eav = mrun && !(mcnt == 3 && pend.size() != 0 && !avail_in);
        chk("avail_out", avail_out, eav);
        chk("valid_out", valid_out, pend.size() != 0);
        if (configure) begin
            pend.delete();
            mcnt  = 0;
            mrun  = (num_iters != 0) && (num_reads_per_iter != 0);
            mleft = int'(num_iters) * int'(num_reads_per_iter);
        end else begin
            if (avail_in && pend.size() != 0) begin
                chk("data_out", data_out, pend[0]);
                void'(pend.pop_front());
                mleft--;
                if (mleft == 0) mrun = 0;
            end
            if (valid_in && eav) begin
                mg[mcnt] = data_in;
                if (mcnt == 3) begin
                    pend.push_back(enc(mg));
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ni, input int nr);
        configure          = 1'b1;
        num_iters          = 16'(ni);
        num_reads_per_iter = 16'(nr);
        valid_in           = 1'b0;
        tick();
        configure = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        valid_in = 1'b1;
        data_in  = v;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        valid_in = 1'b0;
        while (mrun && k < 200) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, mrun}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
        data_in = '0; valid_in = 1'b0; avail_in = 1'b0;
        model_reset();
        #12;
        chk("rst_avail_out", avail_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        tick();

        // Zero-length configure stays idle.
        cfg(0, 5);
        tick();

        // Single word with one repeat and one zero.
        avail_in = 1'b1;
        cfg(1, 1);
        send(8'd5); send(8'd0); send(8'd5); send(8'd7);
        chk("word_5057", data_out, {12'd0, 4'b0010, REP_A, 32'h07050005});
        tick();
        tick();

        // Consumer holds off: the second closing element stalls.
        avail_in = 1'b0;
        cfg(1, 2);
        send(8'd3); send(8'd3); send(8'd3); send(8'd3);
        chk("word_3333", data_out, {12'd0, 4'h0, REP_B, 32'h03030303});
        send(8'd0); send(8'd0); send(8'd0);
        valid_in = 1'b1; data_in = 8'd0;
        tick(); tick();
        avail_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("word_0000", data_out, {12'd0, 4'hF, REP_B, 32'h00000000});
        drain("drain_stall");
        tick();

        // Continuous stream, two iterations of three groups.
        cfg(2, 3);
        for (int i = 0; i < 24; i++) send(8'($urandom_range(0, 3)));
        drain("drain_stream");
        tick();

        // Configure mid-group discards the partial group.
        cfg(1, 2);
        send(8'd9); send(8'd9);
        cfg(1, 1);
        send(8'd1); send(8'd2); send(8'd1); send(8'd0);
        drain("drain_reconf");
        tick();

        // Asynchronous reset mid-run.
        cfg(2, 2);
        avail_in = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(i + 1));
        rst = 1'b0;
        #1;
        chk("midrst_avail_out", avail_out, 0);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_data_out", data_out, 0);
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        tick();

        // Randomized runs with random back-pressure.
        for (int r = 0; r < 6; r++) begin
            int k;
            cfg(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            k = 0;
            while (mrun && k < 2000) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = 8'($urandom_range(0, 3));
                avail_in = ($urandom_range(0, 3) != 0);
                tick();
                k++;
            end
            valid_in = 1'b0;
            chk("rand_timeout", {63'd0, mrun}, 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
